// File: rtl/op_timer_bank.sv
// Multi-channel operator latency profiler: each channel times start->done pulse pairs
// and keeps last/min/max/total/ops statistics plus sticky saturation and protocol-error flags.
module op_timer_bank #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int ACC_W  = 48,
  parameter int OPS_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NUM_CH-1:0] i_start,
  input  logic [NUM_CH-1:0] i_done,
  input  logic              i_clear,
  input  logic              i_rd_en,
  input  logic [3:0]        i_rd_ch,
  input  logic [2:0]        i_rd_sel,
  output logic [ACC_W-1:0]  o_rd_data,
  output logic              o_rd_valid,
  output logic [NUM_CH-1:0] o_busy,
  output logic [NUM_CH-1:0] o_err
);

  localparam logic [0:0]       ST_IDLE = 1'b0;
  localparam logic [0:0]       ST_RUN  = 1'b1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [ACC_W-1:0] ACC_MAX = '1;
  localparam logic [OPS_W-1:0] OPS_MAX = '1;

  logic [CNT_W-1:0] w_last  [NUM_CH];
  logic [CNT_W-1:0] w_min   [NUM_CH];
  logic [CNT_W-1:0] w_max   [NUM_CH];
  logic [ACC_W-1:0] w_total [NUM_CH];
  logic [OPS_W-1:0] w_ops   [NUM_CH];
  logic             w_sat   [NUM_CH];
  logic [ACC_W-1:0] w_rd_mux;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [0:0]       r_state;
      logic [CNT_W-1:0] r_cnt;
      logic [CNT_W-1:0] r_last;
      logic [CNT_W-1:0] r_min;
      logic [CNT_W-1:0] r_max;
      logic [ACC_W-1:0] r_total;
      logic [OPS_W-1:0] r_ops;
      logic             r_sat;
      logic             r_err;
      logic [ACC_W:0]   w_sum;
      logic             w_rec;

      // One extra bit on the sum exposes overflow of the accumulator.
      assign w_sum = {1'b0, r_total} + (ACC_W+1)'(r_cnt);
      assign w_rec = (r_state == ST_RUN) && i_done[gi];

      always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_last  <= '0;
          r_min   <= CNT_MAX;
          r_max   <= '0;
          r_total <= '0;
          r_ops   <= '0;
          r_sat   <= 1'b0;
          r_err   <= 1'b0;
        end else begin
          if (r_state == ST_IDLE) begin
            if (i_done[gi]) r_err <= 1'b1;
            if (i_start[gi]) begin
              r_state <= ST_RUN;
              r_cnt   <= CNT_W'(1);
            end
          end else if (i_done[gi]) begin
            if (i_start[gi]) begin
              r_cnt <= CNT_W'(1);
            end else begin
              r_state <= ST_IDLE;
              r_cnt   <= '0;
            end
          end else begin
            // A restart while running is flagged but the running count keeps going.
            if (i_start[gi]) r_err <= 1'b1;
            if (r_cnt == CNT_MAX) r_sat <= 1'b1;
            else r_cnt <= r_cnt + 1'b1;
          end

          if (w_rec) begin
            r_last <= r_cnt;
            if (r_cnt < r_min) r_min <= r_cnt;
            if (r_cnt > r_max) r_max <= r_cnt;
            if (w_sum[ACC_W]) begin
              r_total <= ACC_MAX;
              r_sat   <= 1'b1;
            end else begin
              r_total <= w_sum[ACC_W-1:0];
            end
            if (r_ops == OPS_MAX) r_sat <= 1'b1;
            else r_ops <= r_ops + 1'b1;
          end
        end
      end

      assign w_last[gi]  = r_last;
      assign w_min[gi]   = r_min;
      assign w_max[gi]   = r_max;
      assign w_total[gi] = r_total;
      assign w_ops[gi]   = r_ops;
      assign w_sat[gi]   = r_sat;
      assign o_busy[gi]  = (r_state == ST_RUN);
      assign o_err[gi]   = r_err;
    end
  endgenerate

  // Out-of-range channel or field falls through to zero.
  always_comb begin
    w_rd_mux = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (i_rd_ch == 4'(c)) begin
        case (i_rd_sel)
          3'd0:    w_rd_mux = ACC_W'(w_last[c]);
          3'd1:    w_rd_mux = ACC_W'(w_min[c]);
          3'd2:    w_rd_mux = ACC_W'(w_max[c]);
          3'd3:    w_rd_mux = w_total[c];
          3'd4:    w_rd_mux = ACC_W'(w_ops[c]);
          3'd5:    w_rd_mux = ACC_W'({w_sat[c], o_err[c], o_busy[c]});
          default: w_rd_mux = '0;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rd_data  <= '0;
      o_rd_valid <= 1'b0;
    end else begin
      o_rd_valid <= i_rd_en;
      if (i_rd_en) o_rd_data <= w_rd_mux;
    end
  end

endmodule
